// File: rtl/alu_multiciclo.sv
// Multicycle ALU: registered single-cycle ops, shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides.
module alu_multiciclo #(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   aluControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultado,
  output logic         cout,
  output logic         zero,
  output logic         neg,
  output logic         overflow,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StHold} state_e;

  state_e          state_q, state_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    res_q, res_d;
  logic            cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic            accept;
  logic [N:0]      sum_w, dif_w;
  logic [N-1:0]    sc_res;
  logic            sc_cout, sc_neg, sc_ovf, sc_zero;

  // Multiply: acc holds {partial product high, remaining multiplier bits}
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_next;
  // Divide: acc holds {remainder, remaining dividend / quotient bits}
  logic [N:0]      div_shift;
  logic [N-1:0]    div_sub;
  logic            div_ge;
  logic [2*N-1:0]  div_next;

  assign in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StMul) | (state_q == StDiv);
  assign resultado = res_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign overflow  = ovf_q;

  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    dif_w   = {1'b0, a} - {1'b0, b};
    sc_res  = '0;
    sc_cout = 1'b0;
    sc_neg  = 1'b0;
    sc_ovf  = 1'b0;
    unique case (aluControl)
      4'b0000: begin
        sc_res  = sum_w[N-1:0];
        sc_cout = sum_w[N];
        sc_neg  = sum_w[N-1];
        sc_ovf  = (a[N-1] == b[N-1]) & (sum_w[N-1] != a[N-1]);
      end
      4'b0001, 4'b0111: begin
        sc_res  = dif_w[N-1:0];
        sc_cout = ~dif_w[N];
        sc_neg  = dif_w[N-1];
        sc_ovf  = (a[N-1] != b[N-1]) & (dif_w[N-1] != a[N-1]);
      end
      4'b0100: sc_res = a >> b[SHW-1:0];
      4'b0101: sc_res = a << b[SHW-1:0];
      4'b0110: sc_res = b;
      4'b1000: sc_res = a & b;
      4'b1001: sc_res = a | b;
      4'b1010: sc_res = ~a;
      4'b1011: sc_res = a ^ b;
      default: sc_res = '0;
    endcase
    // Undefined opcodes report every flag low, including zero.
    sc_zero = (sc_res == '0) & (aluControl[3:2] != 2'b11);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, b_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[N-1:1]} : {1'b0, acc_q[2*N-1:1]};
    div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[N-1:0] - b_q;
    div_next  = div_ge ? {div_sub, acc_q[N-2:0], 1'b1}
                       : {div_shift[N-1:0], acc_q[N-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (aluControl == 4'b0010 || aluControl == 4'b0011) begin
            state_d = (aluControl == 4'b0010) ? StMul : StDiv;
            acc_d   = {{N{1'b0}}, a};
            b_d     = b;
            cnt_d   = CW'(N);
          end else begin
            state_d = StHold;
            res_d   = sc_res;
            cout_d  = sc_cout;
            zero_d  = sc_zero;
            neg_d   = sc_neg;
            ovf_d   = sc_ovf;
          end
        end else if (state_q == StHold && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StHold;
          res_d   = mul_next[N-1:0];
          cout_d  = 1'b0;
          zero_d  = (mul_next[N-1:0] == '0);
          neg_d   = 1'b0;
          ovf_d   = |mul_next[2*N-1:N];
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StHold;
          res_d   = div_next[N-1:0];
          cout_d  = 1'b0;
          zero_d  = (div_next[N-1:0] == '0);
          neg_d   = 1'b0;
          ovf_d   = (b_q == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed self-checking bench for alu_multiciclo at N=8.
module tb_alu_multiciclo;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         in_ready, out_valid, cout, zero, neg, overflow, busy;
  logic [N-1:0] resultado;

  int total = 0;
  int bad   = 0;

  // Observation vector: {out_valid, resultado, cout, zero, neg, overflow}
  logic [N+4:0] obs;
  assign obs = {out_valid, resultado, cout, zero, neg, overflow};

  alu_multiciclo #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .aluControl (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .resultado  (resultado),
    .cout       (cout),
    .zero       (zero),
    .neg        (neg),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  localparam logic [3:0]   AR_OP  [5] = '{4'h0, 4'h0, 4'h1, 4'h7, 4'h1};
  localparam logic [7:0]   AR_A   [5] = '{8'h7F, 8'hFF, 8'h05, 8'h03, 8'h80};
  localparam logic [7:0]   AR_B   [5] = '{8'h01, 8'h01, 8'h05, 8'h05, 8'h01};
  localparam logic [12:0]  AR_EXP [5] = '{{1'b1, 8'h80, 4'b0011}, {1'b1, 8'h00, 4'b1100},
                                          {1'b1, 8'h00, 4'b1100}, {1'b1, 8'hFE, 4'b0010},
                                          {1'b1, 8'h7F, 4'b1001}};

  localparam logic [3:0]   LG_OP  [7] = '{4'h4, 4'h5, 4'h6, 4'hA, 4'h8, 4'hC, 4'hF};
  localparam logic [7:0]   LG_A   [7] = '{8'h80, 8'h81, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h12};
  localparam logic [7:0]   LG_B   [7] = '{8'h0B, 8'h01, 8'h5A, 8'h33, 8'hF0, 8'h00, 8'h34};
  localparam logic [12:0]  LG_EXP [7] = '{{1'b1, 8'h10, 4'b0000}, {1'b1, 8'h02, 4'b0000},
                                          {1'b1, 8'h5A, 4'b0000}, {1'b1, 8'hF0, 4'b0000},
                                          {1'b1, 8'h00, 4'b0100}, {1'b1, 8'h00, 4'b0000},
                                          {1'b1, 8'h00, 4'b0000}};

  // Drive one op for the edge after the next negedge, then scramble inputs.
  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(negedge clk);
    in_valid = 1'b0;
    a  = N'($urandom);
    b  = N'($urandom);
    op = 4'($urandom);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (obs !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got obs=%h busy=%b want obs=0 busy=0", obs, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_arith();
    for (int i = 0; i < 5; i++) begin
      issue(AR_OP[i], AR_A[i], AR_B[i]);
      total++;
      if (obs !== AR_EXP[i]) begin
        bad++;
        $display("FAIL arith[%0d]: got %h want %h", i, obs, AR_EXP[i]);
      end
    end
  endtask

  task automatic test_logic();
    for (int i = 0; i < 7; i++) begin
      issue(LG_OP[i], LG_A[i], LG_B[i]);
      total++;
      if (obs !== LG_EXP[i]) begin
        bad++;
        $display("FAIL logic[%0d]: got %h want %h", i, obs, LG_EXP[i]);
      end
    end
  endtask

  task automatic test_iter(input string name, input logic [3:0] o, input logic [N-1:0] x,
                           input logic [N-1:0] y, input logic [12:0] exp_obs);
    int lat = 0;
    int bcnt = 0;
    issue(o, x, y);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_in_ready: got %b want 0", name, in_ready);
    end
    while (out_valid !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != N) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, N);
    end
    total++;
    if (bcnt != N) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, bcnt, N);
    end
    total++;
    if (obs !== exp_obs) begin
      bad++;
      $display("FAIL %s_result: got %h want %h", name, obs, exp_obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp3 [3];
    exp3[0] = {1'b1, 8'h0C, 4'b0000};
    exp3[1] = {1'b1, 8'h33, 4'b0000};
    exp3[2] = {1'b1, 8'hF0, 4'b0000};
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; op = 4'h8; a = 8'h3C; b = 8'h0F;
    @(negedge clk);
    total++;
    if (obs !== exp3[0]) begin
      bad++;
      $display("FAIL b2b_and: got %h want %h", obs, exp3[0]);
    end
    op = 4'h9; a = 8'h30; b = 8'h03;
    @(negedge clk);
    total++;
    if (obs !== exp3[1]) begin
      bad++;
      $display("FAIL b2b_or: got %h want %h", obs, exp3[1]);
    end
    op = 4'hB; a = 8'hFF; b = 8'h0F;
    @(negedge clk);
    total++;
    if (obs !== exp3[2]) begin
      bad++;
      $display("FAIL b2b_xor: got %h want %h", obs, exp3[2]);
    end
    // Stall: a pending add must not be taken while the result is held.
    op = 4'h0; a = 8'h01; b = 8'h01;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp3[2] || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: got obs=%h in_ready=%b want obs=%h in_ready=0",
                 i, obs, in_ready, exp3[2]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || resultado !== 8'hF0) begin
      bad++;
      $display("FAIL hold_release: got out_valid=%b res=%h want 0 F0", out_valid, resultado);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen = 0;
    issue(4'h3, 8'hC8, 8'h07);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (obs !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_div: got obs=%h busy=%b want 0 0", obs, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_div_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_mid_div_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_iter("mul", 4'h2, 8'h10, 8'h20, {1'b1, 8'h00, 4'b0101});
    test_iter("div", 4'h3, 8'd200, 8'd7, {1'b1, 8'd28, 4'b0000});
    test_iter("div0", 4'h3, 8'd200, 8'd0, {1'b1, 8'hFF, 4'b0001});
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
